stroke_raster_engine: RTL and testbench

- Parametrised successor to the canvas mouse-input path. It queues mouse samples, rasterises the line between consecutive held-button samples with integer Bresenham, and emits one pixel write per cycle into a single locked canvas cell's bitmap RAM.
- Adds multi-bit pen values, an endpoint FIFO with drop reporting, stroke breaks on button release, and a clear sweep that is deferred while a line is in progress.
- Sits between the mouse decoder and the cell bitmap RAM write port.

---
 rtl/stroke_raster_engine.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_stroke_raster_engine.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stroke_raster_engine.sv
// Mouse stroke rasteriser: queues pointer samples, draws Bresenham lines
// between held-button samples into one locked cell's bitmap RAM, and sweeps
// the cell clear on request.
module stroke_raster_engine #(
    parameter int unsigned X_W        = 10,
    parameter int unsigned Y_W        = 10,
    parameter int unsigned CELL_SHIFT = 5,
    parameter int unsigned DATA_W     = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [X_W-1:0]                mouse_x,
    input  logic [Y_W-1:0]                mouse_y,
    input  logic                          mouse_left,
    input  logic                          mouse_right,
    input  logic                          new_event,
    input  logic [DATA_W-1:0]             pen_value,
    input  logic                          clear_req,
    output logic [2*CELL_SHIFT-1:0]       write_addr,
    output logic                          write_enable,
    output logic [DATA_W-1:0]             write_data,
    output logic [X_W-CELL_SHIFT-1:0]     cell_x,
    output logic [Y_W-CELL_SHIFT-1:0]     cell_y,
    output logic                          editing,
    output logic                          busy,
    output logic                          ev_dropped
);

    localparam int unsigned PW    = 2 * CELL_SHIFT;
    localparam int unsigned SW    = ((X_W > Y_W) ? X_W : Y_W) + 2;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CX_W  = X_W - CELL_SHIFT;
    localparam int unsigned CY_W  = Y_W - CELL_SHIFT;
    localparam logic signed [SW-1:0] S_ONE = SW'(1);

    typedef struct packed {
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [DATA_W-1:0] data;
        logic              start;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP, S_CLEAR} state_t;

    state_t               state_q, state_d;
    entry_t               fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    entry_t               ent_q, ent_d;
    logic [X_W-1:0]       last_x_q, last_x_d;
    logic [Y_W-1:0]       last_y_q, last_y_d;
    logic                 pen_up_q, pen_up_d;
    logic                 clear_pend_q, clear_pend_d;
    logic                 editing_q, editing_d;
    logic [CX_W-1:0]      cell_x_q, cell_x_d;
    logic [CY_W-1:0]      cell_y_q, cell_y_d;
    logic signed [SW-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic signed [SW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                 step_x_q, step_x_d, step_y_q, step_y_d;
    logic [PW-1:0]        clr_cnt_q, clr_cnt_d;
    logic [PW-1:0]        write_addr_q, write_addr_d;
    logic                 write_enable_q, write_enable_d;
    logic [DATA_W-1:0]    write_data_q, write_data_d;
    logic                 busy_q, busy_d;
    logic                 ev_dropped_q, ev_dropped_d;

    logic                 in_clear_c, pressed_c, fifo_full_c;
    logic                 push_c, drop_c, pop_c;
    entry_t               push_ent_c;
    logic signed [SW-1:0] sx_c, sy_c, ex_c, ey_c, e2_c;

    assign write_addr   = write_addr_q;
    assign write_enable = write_enable_q;
    assign write_data   = write_data_q;
    assign cell_x       = cell_x_q;
    assign cell_y       = cell_y_q;
    assign editing      = editing_q;
    assign busy         = busy_q;
    assign ev_dropped   = ev_dropped_q;

    // Endpoint queue storage; only the pointers carry reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= push_ent_c;
        end
    end

    // Sample acceptance, queue bookkeeping, FSM next state and registered outputs.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        cnt_d          = cnt_q;
        ent_d          = ent_q;
        last_x_d       = last_x_q;
        last_y_d       = last_y_q;
        pen_up_d       = pen_up_q;
        clear_pend_d   = clear_pend_q;
        editing_d      = editing_q;
        cell_x_d       = cell_x_q;
        cell_y_d       = cell_y_q;
        cur_x_d        = cur_x_q;
        cur_y_d        = cur_y_q;
        dx_d           = dx_q;
        dy_d           = dy_q;
        err_d          = err_q;
        step_x_d       = step_x_q;
        step_y_d       = step_y_q;
        clr_cnt_d      = clr_cnt_q;
        write_addr_d   = write_addr_q;
        write_enable_d = 1'b0;
        write_data_d   = write_data_q;
        sx_c           = '0;
        sy_c           = '0;
        e2_c           = err_q <<< 1;
        ex_c           = SW'(ent_q.x);
        ey_c           = SW'(ent_q.y);

        in_clear_c  = (state_q == S_CLEAR);
        pressed_c   = mouse_left | mouse_right;
        fifo_full_c = (cnt_q == CNT_W'(FIFO_DEPTH));
        push_c      = new_event && pressed_c && !in_clear_c && !fifo_full_c;
        drop_c      = new_event && pressed_c && !in_clear_c && fifo_full_c;
        pop_c       = (state_q == S_IDLE) && !clear_pend_q && (cnt_q != '0);

        push_ent_c.x     = mouse_x;
        push_ent_c.y     = mouse_y;
        push_ent_c.data  = mouse_left ? pen_value : '0;
        push_ent_c.start = pen_up_q;

        ev_dropped_d = drop_c;

        // A released button breaks the stroke; an accepted press continues it.
        if (new_event && !in_clear_c) begin
            if (!pressed_c) begin
                pen_up_d = 1'b1;
            end else if (!fifo_full_c) begin
                pen_up_d = 1'b0;
            end
        end

        if (push_c && !editing_q) begin
            editing_d = 1'b1;
            cell_x_d  = mouse_x[X_W-1:CELL_SHIFT];
            cell_y_d  = mouse_y[Y_W-1:CELL_SHIFT];
        end

        if (clear_req && !in_clear_c) begin
            clear_pend_d = 1'b1;
        end

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            ent_d    = fifo_mem[rd_ptr_q];
        end
        cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);

        case (state_q)
            S_IDLE: begin
                if (clear_pend_q) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '1;
                end else if (cnt_q != '0) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sx_c     = ent_q.start ? SW'(ent_q.x) : SW'(last_x_q);
                sy_c     = ent_q.start ? SW'(ent_q.y) : SW'(last_y_q);
                dx_d     = (ex_c >= sx_c) ? (ex_c - sx_c) : (sx_c - ex_c);
                dy_d     = (ey_c >= sy_c) ? (ey_c - sy_c) : (sy_c - ey_c);
                step_x_d = (ex_c >= sx_c);
                step_y_d = (ey_c >= sy_c);
                err_d    = dx_d - dy_d;
                cur_x_d  = sx_c;
                cur_y_d  = sy_c;
                state_d  = S_STEP;
            end
            S_STEP: begin
                write_addr_d   = {cur_y_q[CELL_SHIFT-1:0], cur_x_q[CELL_SHIFT-1:0]};
                write_data_d   = ent_q.data;
                write_enable_d = (cur_x_q[X_W-1:CELL_SHIFT] == cell_x_q) &&
                                 (cur_y_q[Y_W-1:CELL_SHIFT] == cell_y_q);
                if ((cur_x_q == ex_c) && (cur_y_q == ey_c)) begin
                    last_x_d = ent_q.x;
                    last_y_d = ent_q.y;
                    state_d  = S_IDLE;
                end else begin
                    // Both axis updates test the same e2 so diagonal moves happen in one cycle.
                    if (e2_c > -dy_q) begin
                        err_d   = err_d - dy_q;
                        cur_x_d = step_x_q ? (cur_x_q + S_ONE) : (cur_x_q - S_ONE);
                    end
                    if (e2_c < dx_q) begin
                        err_d   = err_d + dx_q;
                        cur_y_d = step_y_q ? (cur_y_q + S_ONE) : (cur_y_q - S_ONE);
                    end
                end
            end
            S_CLEAR: begin
                write_enable_d = 1'b1;
                write_data_d   = '0;
                write_addr_d   = clr_cnt_q;
                clr_cnt_d      = clr_cnt_q - PW'(1);
                if (clr_cnt_q == '0) begin
                    editing_d    = 1'b0;
                    pen_up_d     = 1'b1;
                    clear_pend_d = 1'b0;
                    wr_ptr_d     = '0;
                    rd_ptr_d     = '0;
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Busy also covers the registered write still in flight after STEP/CLEAR.
        busy_d = (state_d != S_IDLE) || (cnt_d != '0) ||
                 (state_q == S_STEP) || (state_q == S_CLEAR);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            ent_q          <= '0;
            last_x_q       <= '0;
            last_y_q       <= '0;
            pen_up_q       <= 1'b1;
            clear_pend_q   <= 1'b0;
            editing_q      <= 1'b0;
            cell_x_q       <= '0;
            cell_y_q       <= '0;
            cur_x_q        <= '0;
            cur_y_q        <= '0;
            dx_q           <= '0;
            dy_q           <= '0;
            err_q          <= '0;
            step_x_q       <= 1'b0;
            step_y_q       <= 1'b0;
            clr_cnt_q      <= '0;
            write_addr_q   <= '0;
            write_enable_q <= 1'b0;
            write_data_q   <= '0;
            busy_q         <= 1'b0;
            ev_dropped_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            ent_q          <= ent_d;
            last_x_q       <= last_x_d;
            last_y_q       <= last_y_d;
            pen_up_q       <= pen_up_d;
            clear_pend_q   <= clear_pend_d;
            editing_q      <= editing_d;
            cell_x_q       <= cell_x_d;
            cell_y_q       <= cell_y_d;
            cur_x_q        <= cur_x_d;
            cur_y_q        <= cur_y_d;
            dx_q           <= dx_d;
            dy_q           <= dy_d;
            err_q          <= err_d;
            step_x_q       <= step_x_d;
            step_y_q       <= step_y_d;
            clr_cnt_q      <= clr_cnt_d;
            write_addr_q   <= write_addr_d;
            write_enable_q <= write_enable_d;
            write_data_q   <= write_data_d;
            busy_q         <= busy_d;
            ev_dropped_q   <= ev_dropped_d;
        end
    end

endmodule

// File: tb/tb_stroke_raster_engine.sv
// Directed bench for stroke_raster_engine with a write scoreboard.
module tb_stroke_raster_engine;

    logic        clk;
    logic        rst;
    logic [9:0]  mouse_x;
    logic [9:0]  mouse_y;
    logic        mouse_left;
    logic        mouse_right;
    logic        new_event;
    logic [0:0]  pen_value;
    logic        clear_req;
    logic [9:0]  write_addr;
    logic        write_enable;
    logic [0:0]  write_data;
    logic [4:0]  cell_x;
    logic [4:0]  cell_y;
    logic        editing;
    logic        busy;
    logic        ev_dropped;

    int compared   = 0;
    int mismatched = 0;
    int drops      = 0;
    int exp_cx     = 1;
    int exp_cy     = 2;
    int exp_addr[$];
    int exp_data[$];

    stroke_raster_engine dut (
        .clk          (clk),
        .rst          (rst),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .mouse_left   (mouse_left),
        .mouse_right  (mouse_right),
        .new_event    (new_event),
        .pen_value    (pen_value),
        .clear_req    (clear_req),
        .write_addr   (write_addr),
        .write_enable (write_enable),
        .write_data   (write_data),
        .cell_x       (cell_x),
        .cell_y       (cell_y),
        .editing      (editing),
        .busy         (busy),
        .ev_dropped   (ev_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int a, input int d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    // Reference Bresenham over the whole line, keeping only pixels in the locked cell.
    task automatic model_line(input int sx, input int sy, input int ex, input int ey, input int d);
        int x, y, dx, dy, stx, sty, err, e2;
        x   = sx;
        y   = sy;
        dx  = (ex > sx) ? ex - sx : sx - ex;
        dy  = (ey > sy) ? ey - sy : sy - ey;
        stx = (ex >= sx) ? 1 : -1;
        sty = (ey >= sy) ? 1 : -1;
        err = dx - dy;
        for (int k = 0; k < 4096; k++) begin
            if ((x / 32) == exp_cx && (y / 32) == exp_cy)
                push_exp((y % 32) * 32 + (x % 32), d);
            if (x == ex && y == ey) break;
            e2 = 2 * err;
            if (e2 > -dy) begin err -= dy; x += stx; end
            if (e2 < dx)  begin err += dx; y += sty; end
        end
    endtask

    task automatic send_ev(input int x, input int y, input logic l, input logic r);
        mouse_x     = 10'(x);
        mouse_y     = 10'(y);
        mouse_left  = l;
        mouse_right = r;
        new_event   = 1'b1;
        @(negedge clk);
        new_event   = 1'b0;
    endtask

    // Waits for the first write, then counts cycles until busy drops.
    task automatic run_line(input string tag, input int exp_cycles);
        bit seen;
        int n;
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (write_enable) seen = 1;
            else @(negedge clk);
        end
        chk({tag, "_first_write"}, 32'(seen), 1);
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
        chk({tag, "_we_after"}, 32'(write_enable), 0);
        chk({tag, "_sb_empty"}, 32'(exp_addr.size()), 0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy || exp_addr.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy_low"}, 32'(busy), 0);
        chk({tag, "_sb_empty"}, 32'(exp_addr.size()), 0);
    endtask

    // Scoreboard: every RAM write must match the oldest expected write.
    always @(negedge clk) begin
        int ea, ed;
        if (rst && write_enable) begin
            chk("sb_has_entry", 32'(exp_addr.size() != 0), 1);
            if (exp_addr.size() != 0) begin
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                chk("waddr", 32'(write_addr), 32'(ea));
                chk("wdata", 32'(write_data), 32'(ed));
            end
        end
        if (rst && ev_dropped) drops++;
    end

    initial begin
        rst = 1'b0; mouse_x = '0; mouse_y = '0; mouse_left = 1'b0; mouse_right = 1'b0;
        new_event = 1'b0; pen_value = 1'b1; clear_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_we",      32'(write_enable), 0);
        chk("rst_addr",    32'(write_addr), 0);
        chk("rst_data",    32'(write_data), 0);
        chk("rst_cell_x",  32'(cell_x), 0);
        chk("rst_cell_y",  32'(cell_y), 0);
        chk("rst_editing", 32'(editing), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_drop",    32'(ev_dropped), 0);
        rst = 1'b1;
        @(negedge clk);

        // First press locks cell (1,2) and plots a single pixel.
        push_exp(200, 1);
        send_ev(40, 70, 1'b1, 1'b0);
        chk("lock_editing", 32'(editing), 1);
        chk("lock_cell_x",  32'(cell_x), 1);
        chk("lock_cell_y",  32'(cell_y), 2);
        run_line("dot1", 1);

        // Held drag draws a shallow line.
        push_exp(200, 1); push_exp(201, 1); push_exp(234, 1);
        push_exp(235, 1); push_exp(268, 1); push_exp(269, 1);
        send_ev(45, 72, 1'b1, 1'b0);
        run_line("line6", 6);

        // Erase stroke leaving the cell: 24 writes, 31 step cycles.
        send_ev(45, 72, 1'b0, 1'b0);
        push_exp(200, 0);
        send_ev(40, 70, 1'b0, 1'b1);
        run_line("erase_dot", 1);
        for (int i = 0; i < 24; i++) push_exp(200 + i, 0);
        send_ev(70, 70, 1'b0, 1'b1);
        run_line("erase_line", 31);

        // Long line active while five samples arrive back to back.
        model_line(70, 70, 40, 100, 1);
        send_ev(40, 100, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        model_line(40, 100, 42, 98, 1);
        model_line(42, 98, 44, 96, 1);
        model_line(44, 96, 46, 94, 1);
        model_line(46, 94, 48, 92, 1);
        for (int i = 0; i < 5; i++) begin
            send_ev(42 + 2 * i, 98 - 2 * i, 1'b1, 1'b0);
            chk($sformatf("drop_pulse_%0d", i), 32'(ev_dropped), 32'(i == 4));
        end
        wait_idle("fifo", 1000);
        chk("drop_count", 32'(drops), 1);

        // Release breaks the stroke: next press is a lone pixel.
        send_ev(48, 92, 1'b0, 1'b0);
        push_exp(530, 1);
        send_ev(50, 80, 1'b1, 1'b0);
        run_line("break_dot", 1);

        // Clear during a line: line finishes, then full sweep.
        model_line(50, 80, 60, 90, 1);
        send_ev(60, 90, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        for (int a = 1023; a >= 0; a--) push_exp(a, 0);
        repeat (60) @(negedge clk);
        chk("sweep_busy", 32'(busy), 1);
        send_ev(5, 5, 1'b0, 1'b1);
        wait_idle("clear", 3000);
        chk("clear_editing", 32'(editing), 0);
        chk("clear_drop_count", 32'(drops), 1);

        // Relock to a new cell after the clear.
        exp_cx = 3;
        exp_cy = 6;
        push_exp(260, 1);
        send_ev(100, 200, 1'b1, 1'b0);
        chk("relock_editing", 32'(editing), 1);
        chk("relock_cell_x",  32'(cell_x), 3);
        chk("relock_cell_y",  32'(cell_y), 6);
        run_line("relock_dot", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
